// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with stall and flush.
// Optional macro FETCH_STATS_EN adds saturating fetch/bubble counters.
module fetch_stage #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_addr,
    output logic [N-1:0] pc,
    input  logic [N-1:0] instruction_in,
    output logic [N-1:0] if_id_pc,
    output logic [N-1:0] if_id_instruction,
    output logic         if_id_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  bubble_count
`endif
);

    logic [N-1:0] pc_plus4;

    assign pc_plus4 = pc + N'(4);

    // Redirect beats freeze; a flush loads the all-zero NOP word as the bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= {RESET_PC[N-1:2], 2'b00};
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else if (branch_taken) begin
            pc                <= {branch_addr[N-1:2], 2'b00};
            if_id_pc          <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else if (!freeze) begin
            pc                <= pc_plus4;
            if_id_pc          <= pc_plus4;
            if_id_instruction <= instruction_in;
            if_id_valid       <= 1'b1;
        end
    end

`ifdef FETCH_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else if (branch_taken || freeze) begin
            if (bubble_count != 32'hFFFF_FFFF)
                bubble_count <= bubble_count + 32'd1;
        end else begin
            if (fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc;
    logic [31:0] instruction_in;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_ins;
    logic        m_valid;
    longint      m_fetch;
    longint      m_bubble;

    fetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .branch_taken      (branch_taken),
        .branch_addr       (branch_addr),
        .pc                (pc),
        .instruction_in    (instruction_in),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count       (fetch_count),
        .bubble_count      (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: fixed word at 0, hashed nonzero words elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h8020000A;
        return ((a * 32'h9E3779B1) ^ 32'h5A5A0000) | 32'h1;
    endfunction

    always_comb instruction_in = mem_word(pc);

    task automatic model_step(input logic r, input logic f, input logic b, input logic [31:0] a);
        if (r) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_ins = 32'h0; m_valid = 1'b0;
            m_fetch = 0; m_bubble = 0;
        end else if (b) begin
            m_pc = a - (a % 4); m_ifpc = 32'h0; m_ins = 32'h0; m_valid = 1'b0;
            m_bubble = (m_bubble < 64'hFFFFFFFF) ? m_bubble + 1 : m_bubble;
        end else if (f) begin
            m_bubble = (m_bubble < 64'hFFFFFFFF) ? m_bubble + 1 : m_bubble;
        end else begin
            m_ins   = mem_word(m_pc);
            m_pc    = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_fetch = (m_fetch < 64'hFFFFFFFF) ? m_fetch + 1 : m_fetch;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, then settle.
    task automatic drive(input logic r, input logic f, input logic b, input logic [31:0] a);
        @(negedge clk);
        rst = r; freeze = f; branch_taken = b; branch_addr = a;
        @(posedge clk);
        model_step(r, f, b, a);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_1234);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got pc=%h ifpc=%h ins=%h v=%b, expected all zero", pc, if_id_pc, if_id_instruction, if_id_valid);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            exp_pc = 32'(4 * i);
            checks++;
            if (pc !== exp_pc) begin
                errors++;
                $display("[TB] FAIL seq_pc%0d: got %h, expected %h", i, pc, exp_pc);
            end
            if (i == 1) begin
                checks++;
                if ({if_id_instruction, if_id_pc, if_id_valid} !== {32'h8020000A, 32'h4, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL seq_first_fetch: got ins=%h ifpc=%h v=%b, expected 8020000a/4/1", if_id_instruction, if_id_pc, if_id_valid);
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [31:0] held_ins;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_000C);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        held_ins = mem_word(32'hC);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'd16, 32'd16, held_ins, 1'b1}) begin
                errors++;
                $display("[TB] FAIL freeze_hold%0d: got pc=%h ifpc=%h ins=%h v=%b, expected 10/10/%h/1", i, pc, if_id_pc, if_id_instruction, if_id_valid, held_ins);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_instruction} !== {32'd20, mem_word(32'd16)}) begin
            errors++;
            $display("[TB] FAIL freeze_resume: got pc=%h ins=%h, expected 14/%h", pc, if_id_instruction, mem_word(32'd16));
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b0, 1'b1, 32'd300);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0113);
        checks++;
        if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'h110, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL redirect_flush: got pc=%h ifpc=%h ins=%h v=%b, expected 110/0/0/0", pc, if_id_pc, if_id_instruction, if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'h114, 32'h114, mem_word(32'h110), 1'b1}) begin
            errors++;
            $display("[TB] FAIL redirect_fetch: got pc=%h ifpc=%h ins=%h v=%b, expected 114/114/%h/1", pc, if_id_pc, if_id_instruction, if_id_valid, mem_word(32'h110));
        end
    endtask

    task automatic test_branch_with_freeze();
        drive(1'b0, 1'b1, 1'b1, 32'h0000_2007);
        checks++;
        if ({pc, if_id_instruction, if_id_valid} !== {32'h2004, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL branch_over_freeze: got pc=%h ins=%h v=%b, expected 2004/0/0", pc, if_id_instruction, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1}) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got pc=%h ifpc=%h ins=%h v=%b, expected 0/0/%h/1", pc, if_id_pc, if_id_instruction, if_id_valid, mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0802);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_pc, if_id_instruction} !== {32'h804, 32'h804, mem_word(32'h800)}) begin
            errors++;
            $display("[TB] FAIL back_to_back: got pc=%h ifpc=%h ins=%h, expected 804/804/%h", pc, if_id_pc, if_id_instruction, mem_word(32'h800));
        end
    endtask

    task automatic test_reset_mid_action();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_freeze: got pc=%h ifpc=%h ins=%h v=%b, expected all zero", pc, if_id_pc, if_id_instruction, if_id_valid);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h0000_3000);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {32'h4, 32'h4, 32'h8020000A, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_mid_redirect: got pc=%h ifpc=%h ins=%h v=%b, expected 4/4/8020000a/1", pc, if_id_pc, if_id_instruction, if_id_valid);
        end
    endtask

    task automatic test_random();
        logic r, f, b;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0);
            a = $urandom;
            drive(r, f, b, a);
            checks++;
            if ({pc, if_id_pc, if_id_instruction, if_id_valid} !== {m_pc, m_ifpc, m_ins, m_valid}) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got pc=%h ifpc=%h ins=%h v=%b, expected %h/%h/%h/%b", i, pc, if_id_pc, if_id_instruction, if_id_valid, m_pc, m_ifpc, m_ins, m_valid);
            end
`ifdef FETCH_STATS_EN
            checks++;
            if ({fetch_count, bubble_count} !== {32'(m_fetch), 32'(m_bubble)}) begin
                errors++;
                $display("[TB] FAIL random_stats%0d: got %0d/%0d, expected %0d/%0d", i, fetch_count, bubble_count, m_fetch, m_bubble);
            end
`endif
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        checks++;
        if ({fetch_count, bubble_count} !== {32'd10, 32'd3}) begin
            errors++;
            $display("[TB] FAIL stats_counts: got %0d/%0d, expected 10/3", fetch_count, bubble_count);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({fetch_count, bubble_count} !== {32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL stats_reset: got %0d/%0d, expected 0/0", fetch_count, bubble_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        m_pc = 32'h0; m_ifpc = 32'h0; m_ins = 32'h0; m_valid = 1'b0;
        m_fetch = 0; m_bubble = 0;
        test_reset();
        test_sequence();
        test_freeze();
        test_redirect();
        test_branch_with_freeze();
        test_wrap();
        test_back_to_back();
        test_reset_mid_action();
        test_random();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
